// File: rtl/fifo_reader.sv
// fifo_reader: pops a FIFO with one-cycle read latency into a 2-entry skid buffer
// and presents the words on a valid/ready stream, counting deliveries.
module fifo_reader #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             fifo_rd_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] words_out
);
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
   state_t           state;
   logic             inflight;
   logic             capture;
   logic             delivery;
   logic [WIDTH-1:0] b0;
   logic [WIDTH-1:0] b1;
   assign occupancy = state;
   assign out_valid = state != EMPTY;
   assign out_data  = b0;
   assign delivery  = out_valid && out_ready;
   assign capture   = inflight && !flush;
   // Count the in-flight word as already buffered so the two entries can never overflow.
   assign fifo_rd_en = reset && !fifo_empty && !flush &&
                       (({1'b0, occupancy} + {2'b0, inflight}) < (3'd2 + {2'b0, delivery}));
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         inflight  <= 1'b0;
         words_out <= '0;
         b0        <= '0;
         b1        <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (delivery) words_out <= words_out + 1'b1;
         if (flush) state <= EMPTY;
         else begin
            case (state)
               EMPTY: if (capture) begin
                  b0    <= fifo_rd_data;
                  state <= ONE;
               end
               ONE: if (capture && delivery) b0 <= fifo_rd_data;
                  else if (capture) begin
                     b1    <= fifo_rd_data;
                     state <= TWO;
                  end else if (delivery) state <= EMPTY;
               TWO: if (delivery) begin
                  b0    <= b1;
                  b1    <= fifo_rd_data;
                  state <= capture ? TWO : ONE;
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end
endmodule
